// File: rtl/line_sum_generator.sv
// Per-line Σ I, Σ I² and Σ T_k·I generator for the template-matching front end.
// Two-stage pipeline: product registers, then line accumulators feeding the held output registers.
module line_sum_generator #(
  parameter  int unsigned PIXEL_SIZE    = 8,
  parameter  int unsigned LINE_SIZE     = 64,
  parameter  int unsigned NUM_OF_LINES  = 64,
  parameter  int unsigned NUM_TEMPLATES = 4,
  localparam int unsigned SW            = $clog2(LINE_SIZE) + 2*PIXEL_SIZE,
  localparam int unsigned PW            = 2*PIXEL_SIZE,
  localparam int unsigned CW            = $clog2(LINE_SIZE),
  localparam int unsigned LW            = $clog2(NUM_OF_LINES)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  sof,
  input  logic [PIXEL_SIZE-1:0] I_pixel,
  input  logic [PIXEL_SIZE-1:0] T_pixel [NUM_TEMPLATES],
  output logic [SW-1:0]         I_square_out_line_sum,
  output logic [SW-1:0]         I_out_line_sum,
  output logic [SW-1:0]         T_x_I_out_lines_sum [NUM_TEMPLATES],
  output logic                  line_sum_valid,
  output logic [LW-1:0]         line_index,
  output logic                  frame_done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;

  logic          w_accept;
  logic [CW-1:0] w_col_cur;
  logic [LW-1:0] w_line_cur;
  logic          w_col_last;
  logic          w_line_last;

  // sof restarts the frame from any state, so the current position is forced to (0,0) with it
  assign w_accept    = pix_valid & (sof | (r_state == S_RUN));
  assign w_col_cur   = sof ? '0 : r_col;
  assign w_line_cur  = sof ? '0 : r_line;
  assign w_col_last  = (w_col_cur == CW'(LINE_SIZE-1));
  assign w_line_last = (w_line_cur == LW'(NUM_OF_LINES-1));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = (w_col_last && w_line_last) ? S_IDLE : S_RUN;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_accept) begin
      r_col  <= w_col_last ? '0 : w_col_cur + CW'(1);
      r_line <= w_col_last ? (w_line_last ? '0 : w_line_cur + LW'(1)) : w_line_cur;
    end
  end

  logic                  r_s1_valid;
  logic                  r_s1_first;
  logic                  r_s1_last;
  logic [LW-1:0]         r_s1_line;
  logic [PIXEL_SIZE-1:0] r_s1_i;
  logic [PW-1:0]         r_s1_isq;
  logic [PW-1:0]         r_s1_txi [NUM_TEMPLATES];

  // Stage 1: products plus position tags
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_line  <= '0;
      r_s1_i     <= '0;
      r_s1_isq   <= '0;
      for (int k = 0; k < NUM_TEMPLATES; k++) r_s1_txi[k] <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_first <= (w_col_cur == '0);
        r_s1_last  <= w_col_last;
        r_s1_line  <= w_line_cur;
        r_s1_i     <= I_pixel;
        r_s1_isq   <= PW'(I_pixel) * PW'(I_pixel);
        for (int k = 0; k < NUM_TEMPLATES; k++)
          r_s1_txi[k] <= PW'(T_pixel[k]) * PW'(I_pixel);
      end
    end
  end

  logic [SW-1:0] r_acc_i;
  logic [SW-1:0] r_acc_isq;
  logic [SW-1:0] r_acc_txi [NUM_TEMPLATES];
  logic [SW-1:0] w_sum_i;
  logic [SW-1:0] w_sum_isq;
  logic [SW-1:0] w_sum_txi [NUM_TEMPLATES];

  // First pixel of a line seeds the sum from zero, which also discards any aborted partial line
  always_comb begin
    w_sum_i   = (r_s1_first ? '0 : r_acc_i) + SW'(r_s1_i);
    w_sum_isq = (r_s1_first ? '0 : r_acc_isq) + SW'(r_s1_isq);
    for (int k = 0; k < NUM_TEMPLATES; k++)
      w_sum_txi[k] = (r_s1_first ? '0 : r_acc_txi[k]) + SW'(r_s1_txi[k]);
  end

  // Stage 2: accumulate, and present the completed line
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_acc_i               <= '0;
      r_acc_isq             <= '0;
      I_out_line_sum        <= '0;
      I_square_out_line_sum <= '0;
      line_index            <= '0;
      line_sum_valid        <= 1'b0;
      frame_done            <= 1'b0;
      for (int k = 0; k < NUM_TEMPLATES; k++) begin
        r_acc_txi[k]           <= '0;
        T_x_I_out_lines_sum[k] <= '0;
      end
    end else begin
      line_sum_valid <= r_s1_valid & r_s1_last;
      frame_done     <= r_s1_valid & r_s1_last & (r_s1_line == LW'(NUM_OF_LINES-1));
      if (r_s1_valid) begin
        r_acc_i   <= w_sum_i;
        r_acc_isq <= w_sum_isq;
        for (int k = 0; k < NUM_TEMPLATES; k++) r_acc_txi[k] <= w_sum_txi[k];
        if (r_s1_last) begin
          I_out_line_sum        <= w_sum_i;
          I_square_out_line_sum <= w_sum_isq;
          line_index            <= r_s1_line;
          for (int k = 0; k < NUM_TEMPLATES; k++) T_x_I_out_lines_sum[k] <= w_sum_txi[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_sum_generator.sv
// Bench for line_sum_generator: directed scenarios plus random traffic against a line-buffer model.
module tb_line_sum_generator;

  localparam int P  = 8;
  localparam int L  = 4;
  localparam int NL = 2;
  localparam int NT = 2;
  localparam int SW = 18;

  logic          CLK = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic          sof;
  logic [P-1:0]  I_pixel;
  logic [P-1:0]  T_pixel [NT];
  logic [SW-1:0] I_square_out_line_sum;
  logic [SW-1:0] I_out_line_sum;
  logic [SW-1:0] T_x_I_out_lines_sum [NT];
  logic          line_sum_valid;
  logic [0:0]    line_index;
  logic          frame_done;

  line_sum_generator #(
    .PIXEL_SIZE(P), .LINE_SIZE(L), .NUM_OF_LINES(NL), .NUM_TEMPLATES(NT)
  ) dut (
    .CLK(CLK), .reset(reset), .pix_valid(pix_valid), .sof(sof),
    .I_pixel(I_pixel), .T_pixel(T_pixel),
    .I_square_out_line_sum(I_square_out_line_sum), .I_out_line_sum(I_out_line_sum),
    .T_x_I_out_lines_sum(T_x_I_out_lines_sum), .line_sum_valid(line_sum_valid),
    .line_index(line_index), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int due; int line; bit fd; int si; int isq; int t0; int t1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   h_si, h_isq, h_t0, h_t1, h_line;

  bit in_frame;
  int col, line;
  int bi [L], bt0 [L], bt1 [L];

  // Reference: buffer the pixels of a line, sum them when the line completes
  task automatic model_pix(input bit s, input int i, input int t0, input int t1);
    exp_t x;
    if (s) begin
      in_frame = 1; col = 0; line = 0;
    end else if (!in_frame) return;
    bi[col] = i; bt0[col] = t0; bt1[col] = t1;
    col++;
    if (col == L) begin
      x.due = cyc + 2; x.line = line; x.fd = (line == NL-1);
      x.si = 0; x.isq = 0; x.t0 = 0; x.t1 = 0;
      for (int n = 0; n < L; n++) begin
        x.si  += bi[n];
        x.isq += bi[n] * bi[n];
        x.t0  += bt0[n] * bi[n];
        x.t1  += bt1[n] * bi[n];
      end
      q.push_back(x);
      col = 0;
      line++;
      if (line == NL) begin line = 0; in_frame = 0; end
    end
  endtask

  task automatic drive(input bit v, input bit s, input int i, input int t0, input int t1);
    @(posedge CLK); #1;
    pix_valid = v; sof = s;
    I_pixel = 8'(i); T_pixel[0] = 8'(t0); T_pixel[1] = 8'(t1);
    if (v) model_pix(s, i, t0, t1);
  endtask

  task automatic rand_inputs();
    pix_valid = 1'($urandom); sof = 1'($urandom);
    I_pixel = 8'($urandom); T_pixel[0] = 8'($urandom); T_pixel[1] = 8'($urandom);
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK); #1;
    reset = 1'b0;
    rand_inputs();
    q.delete();
    in_frame = 0; col = 0; line = 0;
    h_si = 0; h_isq = 0; h_t0 = 0; h_t1 = 0; h_line = 0;
    repeat (n) begin @(posedge CLK); #1; rand_inputs(); end
    reset = 1'b1; pix_valid = 1'b1; sof = 1'b0;
  endtask

  // Per-cycle monitor: reset zeros, scheduled pulses, otherwise silence and held outputs
  always @(negedge CLK) begin
    if (!reset) begin
      check("rst_valid", line_sum_valid, 0);
      check("rst_fd", frame_done, 0);
      check("rst_idx", line_index, 0);
      check("rst_i", I_out_line_sum, 0);
      check("rst_isq", I_square_out_line_sum, 0);
      check("rst_t0", T_x_I_out_lines_sum[0], 0);
      check("rst_t1", T_x_I_out_lines_sum[1], 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("pulse_valid", line_sum_valid, 1);
      check("pulse_fd", frame_done, e.fd);
      check("pulse_idx", line_index, e.line);
      check("pulse_i", I_out_line_sum, e.si);
      check("pulse_isq", I_square_out_line_sum, e.isq);
      check("pulse_t0", T_x_I_out_lines_sum[0], e.t0);
      check("pulse_t1", T_x_I_out_lines_sum[1], e.t1);
      h_si = e.si; h_isq = e.isq; h_t0 = e.t0; h_t1 = e.t1; h_line = e.line;
    end else begin
      check("no_pulse", line_sum_valid, 0);
      check("no_fd", frame_done, 0);
      check("hold_idx", line_index, h_line);
      check("hold_i", I_out_line_sum, h_si);
      check("hold_isq", I_square_out_line_sum, h_isq);
      check("hold_t0", T_x_I_out_lines_sum[0], h_t0);
      check("hold_t1", T_x_I_out_lines_sum[1], h_t1);
    end
  end

  initial begin
    reset = 1'b0;
    rand_inputs();
    do_reset(3);
    repeat (6) drive(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));

    // basic line
    drive(1, 1, 1, 1, 2);
    for (int i = 2; i <= 4; i++) drive(1, 0, i, 1, 2);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("basic_valid", line_sum_valid, 1);
    check("basic_idx", line_index, 0);
    check("basic_i", I_out_line_sum, 10);
    check("basic_isq", I_square_out_line_sum, 30);
    check("basic_t0", T_x_I_out_lines_sum[0], 10);
    check("basic_t1", T_x_I_out_lines_sum[1], 20);
    check("basic_fd", frame_done, 0);

    // max values on line 0, then line 1 ends the frame
    drive(1, 1, 255, 255, 255);
    repeat (3) drive(1, 0, 255, 255, 255);
    drive(1, 0, 1, 1, 1);
    drive(1, 0, 1, 1, 1);
    @(negedge CLK);
    check("max_valid", line_sum_valid, 1);
    check("max_i", I_out_line_sum, 1020);
    check("max_isq", I_square_out_line_sum, 260100);
    check("max_t0", T_x_I_out_lines_sum[0], 260100);
    check("max_t1", T_x_I_out_lines_sum[1], 260100);
    drive(1, 0, 1, 1, 1);
    drive(1, 0, 1, 1, 1);
    drive(1, 0, 7, 7, 7);
    drive(1, 0, 7, 7, 7);
    @(negedge CLK);
    check("end_valid", line_sum_valid, 1);
    check("end_idx", line_index, 1);
    check("end_fd", frame_done, 1);
    check("end_i", I_out_line_sum, 4);
    check("end_isq", I_square_out_line_sum, 4);
    repeat (6) drive(1, 0, 7, 7, 7);

    // basic line with gaps
    for (int i = 1; i <= 4; i++) begin
      drive(1, i == 1, i, 1, 2);
      repeat (3) drive(0, 0, 0, 0, 0);
    end

    // mid-line sof aborts the partial line
    drive(1, 1, 9, 1, 2);
    drive(1, 0, 9, 1, 2);
    drive(1, 1, 1, 1, 2);
    for (int i = 2; i <= 4; i++) drive(1, 0, i, 1, 2);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("msof_valid", line_sum_valid, 1);
    check("msof_idx", line_index, 0);
    check("msof_i", I_out_line_sum, 10);
    check("msof_isq", I_square_out_line_sum, 30);

    // mid-line reset
    drive(1, 1, 5, 5, 5);
    drive(1, 0, 5, 5, 5);
    do_reset(1);
    drive(1, 1, 2, 3, 3);
    repeat (3) drive(1, 0, 2, 3, 3);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("mrst_valid", line_sum_valid, 1);
    check("mrst_i", I_out_line_sum, 8);
    check("mrst_isq", I_square_out_line_sum, 16);
    check("mrst_t0", T_x_I_out_lines_sum[0], 24);
    check("mrst_t1", T_x_I_out_lines_sum[1], 24);

    // random traffic: gaps, occasional sof and reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
      else drive($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end

    repeat (5) drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
